// File: rtl/wb_openram_bank_shim_pkg.sv
// Shared types and helpers for the multi-bank OpenRAM Wishbone shim.
package wb_openram_pkg;

   // Transaction FSM states.
   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      ACK,
      ERR
   } state_t;

   // Read-latency counter width; holds the largest supported latency (4).
   localparam int CNT_W = 3;

   // Ceiling log2, constant-evaluable for parameter derivation.
   function automatic int clog2(input int value);
      int res;
      int rem;
      res = 0;
      rem = value - 1;
      while (rem > 0) begin
         res = res + 1;
         rem = rem >> 1;
      end
      return res;
   endfunction

   // Bank index width; a single bank still gets one index bit.
   function automatic int bank_bits(input int num_banks);
      return (num_banks > 1) ? clog2(num_banks) : 1;
   endfunction

   // Number of byte lanes in a data word.
   function automatic int bytes_of(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/wb_openram_bank_shim_if.sv
// Wishbone-classic slave bus bundle between the management core and the shim.
interface wb_openram_bank_shim_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    wbs_cyc_i;
   logic                    wbs_stb_i;
   logic                    wbs_we_i;
   logic [DATA_WIDTH/8-1:0] wbs_sel_i;
   logic [31:0]             wbs_adr_i;
   logic [DATA_WIDTH-1:0]   wbs_dat_i;
   logic                    wbs_ack_o;
   logic                    wbs_err_o;
   logic [DATA_WIDTH-1:0]   wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_err_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_err_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_openram_bank_shim_rd_mux.sv
// Picks the latched bank's slice out of the concatenated macro dout bus.
module openram_rd_mux #(
   parameter int NUM_BANKS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int BANK_BITS  = 1
) (
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] dout_i,
   input  logic [BANK_BITS-1:0]            bank_i,
   output logic [DATA_WIDTH-1:0]           data_o
);

   // Slice select; bank 0 sits in the LSBs.
   always_comb begin
      data_o = '0;
      for (int i = 0; i < NUM_BANKS; i++) begin
         if (32'(bank_i) == i) begin
            data_o = dout_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: rtl/wb_openram_bank_shim.sv
// Wishbone-classic slave mapping a byte window onto NUM_BANKS single-port
// OpenRAM 1rw macros. Every output, including the macro controls, is a flop.
module wb_openram_bank_shim
   import wb_openram_pkg::*;
#(
   parameter int NUM_BANKS    = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                           wb_clk_i,
   input  logic                           resetb,
   wb_openram_bank_shim_if.slave          wbs,
   output logic [NUM_BANKS-1:0]           ram_csb_o,
   output logic                           ram_web_o,
   output logic [DATA_WIDTH/8-1:0]        ram_wmask_o,
   output logic [ADDR_WIDTH-1:0]          ram_addr_o,
   output logic [DATA_WIDTH-1:0]          ram_din_o,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] ram_dout_i
);

   localparam int BANK_BITS = bank_bits(NUM_BANKS);
   localparam int BYTES     = bytes_of(DATA_WIDTH);
   localparam int BANK_LSB  = ADDR_WIDTH + 2;
   localparam int BANK_MSB  = ADDR_WIDTH + BANK_BITS + 1;

   state_t                  state_q, state_d;
   logic [NUM_BANKS-1:0]    csb_q, csb_d;
   logic                    web_q, web_d;
   logic [BYTES-1:0]        wmask_q, wmask_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   din_q, din_d;
   logic                    ack_q, ack_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   dat_q, dat_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [BANK_BITS-1:0]    bank_q, bank_d;

   logic [ADDR_WIDTH-1:0]   req_word;
   logic [BANK_BITS-1:0]    req_bank;
   logic                    req_bank_ok;
   logic                    req;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic                    unused_adr;

   // Address decode: byte offset and bits above the bank field are don't-care.
   always_comb begin
      req_word    = wbs.wbs_adr_i[BANK_LSB-1:2];
      req_bank    = wbs.wbs_adr_i[BANK_MSB:BANK_LSB];
      req_bank_ok = (32'(req_bank) < NUM_BANKS);
      req         = wbs.wbs_cyc_i && wbs.wbs_stb_i;
   end

   assign unused_adr = ^{wbs.wbs_adr_i[31:BANK_MSB+1], wbs.wbs_adr_i[1:0]};

   openram_rd_mux #(
      .NUM_BANKS  (NUM_BANKS),
      .DATA_WIDTH (DATA_WIDTH),
      .BANK_BITS  (BANK_BITS)
   ) u_rd_mux (
      .dout_i (ram_dout_i),
      .bank_i (bank_q),
      .data_o (rd_data)
   );

   // Next-state and next-output logic; csb/web/wmask default to idle each cycle
   // so a macro access lasts exactly one clock.
   always_comb begin
      state_d = state_q;
      csb_d   = '1;
      web_d   = 1'b1;
      wmask_d = '0;
      addr_d  = addr_q;
      din_d   = din_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
      cnt_d   = cnt_q;
      bank_d  = bank_q;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (!req_bank_ok) begin
                  state_d = ERR;
               end else if (wbs.wbs_we_i) begin
                  state_d = WRITE;
                  csb_d   = ~(NUM_BANKS'(1) << req_bank);
                  web_d   = 1'b0;
                  wmask_d = wbs.wbs_sel_i;
                  addr_d  = req_word;
                  din_d   = wbs.wbs_dat_i;
               end else begin
                  state_d = READ;
                  csb_d   = ~(NUM_BANKS'(1) << req_bank);
                  addr_d  = req_word;
                  cnt_d   = CNT_W'(READ_LATENCY);
                  bank_d  = req_bank;
               end
            end
         end
         // Macro samples the write on this cycle's closing edge; ack follows.
         WRITE: begin
            state_d = wbs.wbs_cyc_i ? ACK : IDLE;
            ack_d   = wbs.wbs_cyc_i;
         end
         // Unmapped bank: one dead cycle mirrors the write slot, then err.
         ERR: begin
            state_d = wbs.wbs_cyc_i ? ACK : IDLE;
            err_d   = wbs.wbs_cyc_i;
         end
         READ: begin
            if (!wbs.wbs_cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = ACK;
               ack_d   = 1'b1;
               dat_d   = rd_data;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         // Response pulse cycle (ack or err); stb is not sampled here.
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
         state_q <= IDLE;
         csb_q   <= '1;
         web_q   <= 1'b1;
         wmask_q <= '0;
         addr_q  <= '0;
         din_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         dat_q   <= '0;
         cnt_q   <= '0;
         bank_q  <= '0;
      end else begin
         state_q <= state_d;
         csb_q   <= csb_d;
         web_q   <= web_d;
         wmask_q <= wmask_d;
         addr_q  <= addr_d;
         din_q   <= din_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         dat_q   <= dat_d;
         cnt_q   <= cnt_d;
         bank_q  <= bank_d;
      end
   end

   assign ram_csb_o     = csb_q;
   assign ram_web_o     = web_q;
   assign ram_wmask_o   = wmask_q;
   assign ram_addr_o    = addr_q;
   assign ram_din_o     = din_q;
   assign wbs.wbs_ack_o = ack_q;
   assign wbs.wbs_err_o = err_q;
   assign wbs.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_openram_bank_shim.sv
// Directed bench: DUT A uses default parameters, DUT B uses three banks and
// a three-clock macro read latency. Behavioural macros sit behind each DUT.
module tb_wb_openram_bank_shim;

   logic clk = 1'b0;
   logic resetb = 1'b0;
   always #5 clk = ~clk;

   // Shared request drivers, steered to one DUT by tgt.
   int          tgt = 0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = '0;
   logic [31:0] adr = '0, dat = '0;

   wb_openram_bank_shim_if #(.DATA_WIDTH(32)) ifa ();
   wb_openram_bank_shim_if #(.DATA_WIDTH(32)) ifb ();

   assign ifa.wbs_cyc_i = cyc && (tgt == 0);
   assign ifa.wbs_stb_i = stb && (tgt == 0);
   assign ifb.wbs_cyc_i = cyc && (tgt == 1);
   assign ifb.wbs_stb_i = stb && (tgt == 1);
   assign ifa.wbs_we_i  = we;
   assign ifb.wbs_we_i  = we;
   assign ifa.wbs_sel_i = sel;
   assign ifb.wbs_sel_i = sel;
   assign ifa.wbs_adr_i = adr;
   assign ifb.wbs_adr_i = adr;
   assign ifa.wbs_dat_i = dat;
   assign ifb.wbs_dat_i = dat;

   logic [1:0]  csb_a;  logic web_a;  logic [3:0] wmask_a;  logic [7:0] addr_a;
   logic [31:0] din_a;  logic [63:0] dout_a = '0;
   logic [2:0]  csb_b;  logic web_b;  logic [3:0] wmask_b;  logic [7:0] addr_b;
   logic [31:0] din_b;  logic [95:0] rd0_b = '0, pipe1_b = '0, pipe2_b = '0;

   wb_openram_bank_shim #(.NUM_BANKS(2), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(1)) dut_a (
      .wb_clk_i (clk), .resetb (resetb), .wbs (ifa),
      .ram_csb_o (csb_a), .ram_web_o (web_a), .ram_wmask_o (wmask_a),
      .ram_addr_o (addr_a), .ram_din_o (din_a), .ram_dout_i (dout_a)
   );

   wb_openram_bank_shim #(.NUM_BANKS(3), .ADDR_WIDTH(8), .DATA_WIDTH(32), .READ_LATENCY(3)) dut_b (
      .wb_clk_i (clk), .resetb (resetb), .wbs (ifb),
      .ram_csb_o (csb_b), .ram_web_o (web_b), .ram_wmask_o (wmask_b),
      .ram_addr_o (addr_b), .ram_din_o (din_b), .ram_dout_i (pipe2_b)
   );

   // Macro models: 1rw, byte-masked write, registered read.
   logic [31:0] mem_a [0:1][0:255];
   logic [31:0] mem_b [0:2][0:255];

   always @(posedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (!csb_a[b]) begin
            if (!web_a) begin
               for (int j = 0; j < 4; j++)
                  if (wmask_a[j]) mem_a[b][addr_a][8*j +: 8] <= din_a[8*j +: 8];
            end else begin
               dout_a[32*b +: 32] <= mem_a[b][addr_a];
            end
         end
      end
   end

   always @(posedge clk) begin
      pipe1_b <= rd0_b;
      pipe2_b <= pipe1_b;
      for (int b = 0; b < 3; b++) begin
         if (!csb_b[b]) begin
            if (!web_b) begin
               for (int j = 0; j < 4; j++)
                  if (wmask_b[j]) mem_b[b][addr_b][8*j +: 8] <= din_b[8*j +: 8];
            end else begin
               rd0_b[32*b +: 32] <= mem_b[b][addr_b];
            end
         end
      end
   end

   // Observation of the targeted DUT.
   logic        o_ack, o_err, o_web;
   logic [31:0] o_dat, o_din;
   logic [7:0]  o_csb, o_addr, csb_idle;
   logic [3:0]  o_wmask;
   assign o_ack    = (tgt == 0) ? ifa.wbs_ack_o : ifb.wbs_ack_o;
   assign o_err    = (tgt == 0) ? ifa.wbs_err_o : ifb.wbs_err_o;
   assign o_dat    = (tgt == 0) ? ifa.wbs_dat_o : ifb.wbs_dat_o;
   assign o_csb    = (tgt == 0) ? {6'b0, csb_a} : {5'b0, csb_b};
   assign o_web    = (tgt == 0) ? web_a : web_b;
   assign o_wmask  = (tgt == 0) ? wmask_a : wmask_b;
   assign o_addr   = (tgt == 0) ? addr_a : addr_b;
   assign o_din    = (tgt == 0) ? din_a : din_b;
   assign csb_idle = (tgt == 0) ? 8'h03 : 8'h07;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-access observations.
   int          n_resp, csb_low_cycles;
   logic        was_err, ack_seen, err_seen, pulse_after;
   logic [7:0]  csb1, addr1;
   logic        web1;
   logic [3:0]  wmask1;
   logic [31:0] din1;

   // One Wishbone access. n_resp = clocks from strobe sample to the first
   // response (0 if none within budget). abort_at drops cyc at that clock.
   task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int abort_at);
      n_resp = 0; was_err = 1'b0; ack_seen = 1'b0; err_seen = 1'b0;
      csb_low_cycles = 0; pulse_after = 1'b0;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); @(negedge clk);
         if (n == 1) begin
            csb1 = o_csb; web1 = o_web; addr1 = o_addr; wmask1 = o_wmask; din1 = o_din;
         end
         if (o_csb != csb_idle) csb_low_cycles++;
         if (o_ack) ack_seen = 1'b1;
         if (o_err) err_seen = 1'b1;
         if (n == abort_at) begin cyc = 1'b0; stb = 1'b0; end
         if ((o_ack || o_err) && n_resp == 0) begin
            n_resp = n; was_err = o_err;
            cyc = 1'b0; stb = 1'b0;
            if (abort_at == 0) break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); @(negedge clk);
      pulse_after = o_ack || o_err;
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      tgt = 0;
      check("rst_csb", o_csb, 8'h03);
      check("rst_web", o_web, 1'b1);
      check("rst_wmask_addr_din", {o_wmask, o_addr, o_din}, '0);
      check("rst_ack_err_dat", {o_ack, o_err, o_dat}, '0);
      resetb = 1'b1;
      @(negedge clk);

      // Write then read, default configuration.
      access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
      check("wr_lat", n_resp, 2);
      check("wr_csb", csb1, 8'h02);
      check("wr_web", web1, 1'b0);
      check("wr_addr", addr1, 8'd4);
      check("wr_wmask", wmask1, 4'hF);
      check("wr_din", din1, 32'hDEAD_BEEF);
      check("wr_csb_cycles", csb_low_cycles, 1);
      check("wr_pulse_len", pulse_after, 1'b0);
      access(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0);
      check("rd_lat", n_resp, 3);
      check("rd_csb_web", {csb1, 7'b0, web1}, {8'h02, 8'h01});
      check("rd_dat", o_dat, 32'hDEAD_BEEF);
      check("rd_pulse_len", pulse_after, 1'b0);

      // Bank select.
      access(1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 0);
      check("b1_csb", csb1, 8'h01);
      check("b1_addr", addr1, 8'd0);
      access(1'b1, 32'h0000_0000, 32'hCAFE_0000, 4'hF, 0);
      check("b0_wr_lat", n_resp, 2);
      access(1'b0, 32'h0000_0000, 32'h0, 4'hF, 0);
      check("b0_rd_dat", o_dat, 32'hCAFE_0000);
      access(1'b0, 32'h0000_0400, 32'h0, 4'hF, 0);
      check("b1_rd_dat", o_dat, 32'h1234_5678);

      // Byte mask, including an all-zero select.
      access(1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, 0);
      access(1'b1, 32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 0);
      check("mask_wmask", wmask1, 4'b0101);
      access(1'b0, 32'h0000_0008, 32'h0, 4'hF, 0);
      check("mask_rd", o_dat, 32'h11BB_33DD);
      access(1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 0);
      check("sel0_lat", n_resp, 2);
      check("sel0_wmask", wmask1, 4'h0);
      access(1'b0, 32'h0000_0008, 32'h0, 4'hF, 0);
      check("sel0_rd", o_dat, 32'h11BB_33DD);

      // Three banks, latency 3.
      tgt = 1;
      access(1'b1, 32'h0000_0800, 32'h5555_AAAA, 4'hF, 0);
      check("b2_csb", csb1, 8'h03);
      check("b2_wr_lat", n_resp, 2);
      access(1'b0, 32'h0000_0800, 32'h0, 4'hF, 0);
      check("lat3_rd", n_resp, 5);
      check("lat3_dat", o_dat, 32'h5555_AAAA);

      // Unmapped bank 3.
      access(1'b0, 32'h0000_0C00, 32'h0, 4'hF, 0);
      check("err_lat", n_resp, 2);
      check("err_flag", was_err, 1'b1);
      check("err_no_ack", ack_seen, 1'b0);
      check("err_no_csb", csb_low_cycles, 0);
      check("err_dat", o_dat, 32'h5555_AAAA);
      check("err_pulse_len", pulse_after, 1'b0);
      access(1'b1, 32'h0000_0C04, 32'h0BAD_0BAD, 4'hF, 0);
      check("err_wr", {n_resp[7:0], 7'b0, was_err}, {8'd2, 8'h01});

      // Abort: cyc dropped at strobe+2 during a latency-3 read.
      access(1'b1, 32'h0000_0800, 32'h7777_8888, 4'hF, 0);
      access(1'b0, 32'h0000_0800, 32'h0, 4'hF, 2);
      check("abort_no_resp", {ack_seen, err_seen}, 2'b00);
      check("abort_csb_cycles", csb_low_cycles, 1);
      check("abort_dat", o_dat, 32'h5555_AAAA);
      access(1'b1, 32'h0000_0004, 32'h0102_0304, 4'hF, 0);
      check("after_abort_wr", n_resp, 2);
      access(1'b0, 32'h0000_0004, 32'h0, 4'hF, 0);
      check("after_abort_rd", o_dat, 32'h0102_0304);

      // Asynchronous reset in the middle of a read.
      tgt = 0;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0000_0010; sel = 4'hF;
      @(posedge clk); @(negedge clk);
      check("arst_pre_csb", o_csb, 8'h02);
      #2 resetb = 1'b0;
      #1;
      check("arst_csb_web", {o_csb, 7'b0, o_web}, {8'h03, 8'h01});
      check("arst_addr_wmask", {o_addr, o_wmask}, '0);
      check("arst_ack_dat", {o_ack, o_err, o_dat}, '0);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      resetb = 1'b1;
      ack_seen = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (o_ack || o_err) ack_seen = 1'b1;
      end
      check("arst_no_ack", ack_seen, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/wb_openram_bank_shim.md
Name: wb_openram_bank_shim

Overview:
Wishbone-classic slave that maps a byte-addressed window onto NUM_BANKS single-port OpenRAM macros (sky130 1rw style: csb/web/wmask/addr/din/dout). It is the parametrised successor of the single-macro shim. It adds generalised data width, bank count and macro read latency, error termination for unmapped banks, and abort on cycle drop. It sits in the user project area between the Caravel management Wishbone and the RAM macros.

Parameters:
NUM_BANKS, 2, number of RAM macros (1..8)
ADDR_WIDTH, 8, word-address bits per macro
DATA_WIDTH, 32, macro and Wishbone data width (multiple of 8)
READ_LATENCY, 1, clocks from the csb-low edge until dout is valid (1..4)
BANK_BITS, derived as max(1,clog2(NUM_BANKS)), bank index width

Ports:
wb_clk_i  in  1  system clock; the macros share it
resetb  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe (window already decoded upstream)
wbs_we_i  in  1  write enable
wbs_sel_i  in  DATA_WIDTH/8  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  DATA_WIDTH  write data
wbs_ack_o  out  1  acknowledge pulse
wbs_err_o  out  1  error pulse
wbs_dat_o  out  DATA_WIDTH  registered read data
ram_csb_o  out  NUM_BANKS  per-bank chip select, active low
ram_web_o  out  1  write enable, active low (shared)
ram_wmask_o  out  DATA_WIDTH/8  byte write mask (shared)
ram_addr_o  out  ADDR_WIDTH  word address (shared)
ram_din_o  out  DATA_WIDTH  write data (shared)
ram_dout_i  in  NUM_BANKS*DATA_WIDTH  concatenated macro outputs; bank 0 in the LSBs

Behaviour:
- Decode: word = adr[ADDR_WIDTH+1:2]; bank = adr[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2]; adr[1:0] and higher bits are ignored.
- Reset (resetb low, async): state IDLE, ram_csb_o all 1, ram_web_o 1, ram_wmask_o 0, ram_addr_o 0, ram_din_o 0, wbs_ack_o 0, wbs_err_o 0, wbs_dat_o 0, latency counter 0.
- All outputs are registered. RAM signals are driven from flops so the macro samples them on the next rising edge.
- IDLE, on cyc&stb:
  - bank>=NUM_BANKS -> ERR. No csb asserted.
  - we=1 -> WRITE. csb[bank]=0, web=0, wmask=sel, din=dat_i for exactly one cycle.
  - we=0 -> READ. csb[bank]=0, web=1 for one cycle; latency counter loaded with READ_LATENCY; selected bank latched.
- WRITE -> ACK: ack=1 for one cycle, asserted 2 clocks after the strobe is sampled.
- READ: csb returns to all-1 after one cycle; the counter decrements each clock. At 0, wbs_dat_o is captured from the latched bank's dout slice and the FSM goes to ACK. Read ack arrives READ_LATENCY+2 clocks after the strobe is sampled.
- ERR: err=1 for one cycle, then IDLE. wbs_dat_o is unchanged.
- ACK: ack=1 for one cycle, then IDLE. stb is not sampled in the ACK/ERR cycle, so back-to-back requests start the cycle after the pulse.
- ack and err are never high together, and never for more than one cycle per request.
- cyc drops in any non-IDLE state: return to IDLE next cycle with no ack/err; csb forced all-1. A write already presented to the macro is not undone. Read data from an aborted read is discarded (wbs_dat_o keeps its old value).
- sel=0 on a write: access still performed with wmask=0 (no bytes change) and acked normally.
- Only one bank's csb is ever low, and for at most one cycle per request.

Decomposition:
- Package wb_openram_pkg: state enum (IDLE, WRITE, READ, ACK, ERR), clog2 function, width helpers (BYTES=DATA_WIDTH/8).
- One natural sub-module, openram_rd_mux: selects the bank slice of ram_dout_i by latched bank index. Combinational, parametrised by NUM_BANKS/DATA_WIDTH.

Test Plan:
- Write then read, defaults: write 0xDEADBEEF to adr 0x0000_0010 (bank0, word4), sel=0xF -> csb=2'b10, web=0, addr=4 for one cycle; ack 2 clocks after strobe. Read same address, macro model returns 0xDEADBEEF -> ack 3 clocks after strobe, dat_o=0xDEADBEEF.
- Bank select: write 0x12345678 to adr 0x400 (bank1, word0) -> csb=2'b01. Then read adr 0x000 -> returns bank0 data, not 0x12345678.
- Byte mask: write 0xAABBCCDD over 0x11223344 with sel=4'b0101 -> wmask=0101; readback 0x11BB33DD.
- Error: NUM_BANKS=3, adr bank index 3 -> err pulse 2 clocks after strobe, ack stays 0, csb stays all-1, dat_o unchanged.
- Latency / abort: READ_LATENCY=3 -> ack at strobe+5. Dropping cyc at strobe+2 -> no ack, FSM back in IDLE, next write acked normally.
- Async reset mid-read: resetb low between csb and ack -> outputs go immediately to reset values, no ack after release.
